// File: rtl/axi_fetch_unit.sv
// axi_fetch_unit
//   Instruction fetch front end. Issues fixed-length INCR bursts on an AXI4
//   read channel, splits each data beat into 32-bit instruction words and
//   buffers them in a first-word fall-through FIFO for the consumer.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   entry                 start PC, loaded while reset is high
//   redirect_valid/_pc    one-cycle PC redirect (flushes the buffer)
//   m_axi_ar*             AXI4 read address channel (master side)
//   m_axi_r*              AXI4 read data channel (master side)
//   inst_valid/_ready     instruction handshake
//   inst_data, inst_pc    head instruction word and its PC
//   halt                  sticky, an all-zero beat was fetched
//   bus_err               sticky, a beat came back with a non-OKAY response
//
// Build option
//   FETCH_TRACE_EN        when defined, every instruction pop prints
//                         "PC 0x<pc>: Instruction 0x<inst>"
//
// state | meaning
// IDLE  | wait for room for a whole burst in the buffer
// ADDR  | AR request outstanding
// DATA  | accepting beats and pushing instructions
// FLUSH | draining beats of an abandoned burst until rlast
// STOP  | halted or bus error, waiting for redirect or reset

module axi_fetch_unit #(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int BURST_LEN  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] entry,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [31:0]           inst_data,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic                  halt,
    output logic                  bus_err
);

    localparam int LANES      = DATA_WIDTH / 32;
    localparam int BEAT_BYTES = DATA_WIDTH / 8;
    localparam int OFF_W      = $clog2(BEAT_BYTES);
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = PTR_W + 1;
    localparam int ADMIT_MAX  = FIFO_DEPTH - BURST_LEN * LANES;

    localparam logic [ADDR_WIDTH-1:0] BEAT_INC    = ADDR_WIDTH'(BEAT_BYTES);
    localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_LEN * BEAT_BYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK  = ~ADDR_WIDTH'(BEAT_BYTES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] ar_addr_q;
    logic [ADDR_WIDTH-1:0] beat_pc;
    logic                  redir_pend;

    logic [ADDR_WIDTH-1:0] pc_mem   [FIFO_DEPTH];
    logic [31:0]           data_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;

    logic                  r_fire;
    logic                  beat_err;
    logic                  beat_zero;
    logic                  push_beat;
    logic                  pop;
    logic                  room_for_burst;
    logic [ADDR_WIDTH-1:0] lane_pc  [LANES];
    logic                  push_en  [LANES];
    logic [PTR_W-1:0]      push_off [LANES];
    logic [CNT_W-1:0]      push_cnt;

    logic [ID_WIDTH-1:0]   unused_rid;
    assign unused_rid = m_axi_rid;

    assign m_axi_arvalid = (state == S_ADDR);
    assign m_axi_araddr  = m_axi_arvalid ? ar_addr_q : '0;
    assign m_axi_arlen   = m_axi_arvalid ? 8'(BURST_LEN - 1) : '0;
    assign m_axi_arsize  = m_axi_arvalid ? 3'(OFF_W) : '0;
    assign m_axi_arburst = m_axi_arvalid ? 2'b01 : 2'b00;
    assign m_axi_arcache = m_axi_arvalid ? 4'b0011 : 4'b0000;
    assign m_axi_arprot  = m_axi_arvalid ? 3'b100 : 3'b000;
    assign m_axi_arid    = '0;
    assign m_axi_arlock  = 1'b0;

    assign m_axi_rready = (state == S_DATA) || (state == S_FLUSH);

    assign r_fire    = m_axi_rvalid && m_axi_rready;
    assign beat_err  = (m_axi_rresp != 2'b00);
    assign beat_zero = (m_axi_rdata == '0);
    // A redirect in the same cycle wins over the push.
    assign push_beat = (state == S_DATA) && r_fire && !beat_err && !beat_zero && !redirect_valid;

    assign inst_valid     = (count != '0);
    assign inst_data      = data_mem[rd_ptr];
    assign inst_pc        = pc_mem[rd_ptr];
    assign pop            = inst_valid && inst_ready;
    assign room_for_burst = (count <= CNT_W'(ADMIT_MAX));

    // Lanes below fetch_pc belong to a mid-beat entry point and are skipped;
    // the surviving lanes are packed into consecutive FIFO slots.
    always_comb begin
        push_cnt = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_pc[k]  = beat_pc + ADDR_WIDTH'(4 * k);
            push_en[k]  = push_beat && (lane_pc[k] >= fetch_pc);
            push_off[k] = push_cnt[PTR_W-1:0];
            if (push_en[k]) begin
                push_cnt = push_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            fetch_pc   <= entry;
            ar_addr_q  <= '0;
            beat_pc    <= '0;
            redir_pend <= 1'b0;
            halt       <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                halt     <= 1'b0;
                bus_err  <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (!redirect_valid && !halt && !bus_err && room_for_burst) begin
                        state      <= S_ADDR;
                        ar_addr_q  <= fetch_pc & ALIGN_MASK;
                        redir_pend <= 1'b0;
                    end
                end
                S_ADDR: begin
                    // A redirect cannot withdraw an AR already on the bus, and
                    // once accepted its beats must be drained before re-fetching.
                    if (m_axi_arready) begin
                        beat_pc    <= ar_addr_q;
                        state      <= (redirect_valid || redir_pend) ? S_FLUSH : S_DATA;
                        redir_pend <= 1'b0;
                    end else if (redirect_valid) begin
                        redir_pend <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_fire) begin
                        beat_pc <= beat_pc + BEAT_INC;
                        if (redirect_valid) begin
                            state <= m_axi_rlast ? S_IDLE : S_FLUSH;
                        end else if (beat_err || beat_zero) begin
                            if (beat_err) begin
                                bus_err <= 1'b1;
                            end else begin
                                halt <= 1'b1;
                            end
                            state <= m_axi_rlast ? S_STOP : S_FLUSH;
                        end else if (m_axi_rlast) begin
                            fetch_pc <= ar_addr_q + BURST_BYTES;
                            state    <= S_IDLE;
                        end
                    end else if (redirect_valid) begin
                        state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (r_fire && m_axi_rlast) begin
                        state <= (!redirect_valid && (halt || bus_err)) ? S_STOP : S_IDLE;
                    end
                end
                S_STOP: begin
                    if (redirect_valid) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + push_cnt[PTR_W-1:0];
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + push_cnt - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (push_en[k]) begin
                pc_mem[wr_ptr + push_off[k]]   <= lane_pc[k];
                data_mem[wr_ptr + push_off[k]] <= m_axi_rdata[32*k +: 32];
            end
        end
    end

`ifdef FETCH_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset && pop) begin
            $display("PC 0x%0h: Instruction 0x%08h", inst_pc, inst_data);
        end
    end
`endif

endmodule

// File: tb/tb_axi_fetch_unit.sv
// Directed bench for axi_fetch_unit with default parameters. The bench acts
// as the AXI slave; memory word at address a is 0xA0000000 + a.
module tb_axi_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] entry;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [12:0] arid;
    logic [63:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [12:0] rid;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [63:0] inst_pc;
    logic        halt;
    logic        bus_err;

    int n_assert = 0;
    int n_fail   = 0;

    logic [63:0] q_pc[$];
    logic [31:0] q_data[$];

    always #5 clk = ~clk;

    axi_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .entry          (entry),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .m_axi_arid     (arid),
        .m_axi_araddr   (araddr),
        .m_axi_arlen    (arlen),
        .m_axi_arsize   (arsize),
        .m_axi_arburst  (arburst),
        .m_axi_arlock   (arlock),
        .m_axi_arcache  (arcache),
        .m_axi_arprot   (arprot),
        .m_axi_arvalid  (arvalid),
        .m_axi_arready  (arready),
        .m_axi_rid      (rid),
        .m_axi_rdata    (rdata),
        .m_axi_rresp    (rresp),
        .m_axi_rlast    (rlast),
        .m_axi_rvalid   (rvalid),
        .m_axi_rready   (rready),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .halt           (halt),
        .bus_err        (bus_err)
    );

    // Record every instruction the consumer takes.
    always @(posedge clk) begin
        if (!reset && inst_valid && inst_ready) begin
            q_pc.push_back(inst_pc);
            q_data.push_back(inst_data);
        end
    end

    function automatic logic [31:0] mem_word(input logic [63:0] pc);
        return 32'hA000_0000 + pc[31:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [63:0] ent);
        reset          = 1'b1;
        entry          = ent;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        arready        = 1'b0;
        rvalid         = 1'b0;
        rdata          = '0;
        rresp          = 2'b00;
        rlast          = 1'b0;
        rid            = '0;
        repeat (2) tick();
        check("rst_arvalid", arvalid, 1'b0);
        check("rst_araddr", araddr, 64'h0);
        check("rst_rready", rready, 1'b0);
        check("rst_inst_valid", inst_valid, 1'b0);
        check("rst_halt", halt, 1'b0);
        check("rst_bus_err", bus_err, 1'b0);
        reset = 1'b0;
        q_pc.delete();
        q_data.delete();
    endtask

    task automatic wait_ar(input string tag, input logic [63:0] exp_addr, input int hold);
        int n;
        n = 0;
        while (!arvalid && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_arvalid"}, arvalid, 1'b1);
        check({tag, "_araddr"}, araddr, exp_addr);
        check({tag, "_arlen"}, arlen, 8'd7);
        check({tag, "_arsize"}, arsize, 3'd3);
        check({tag, "_arburst"}, arburst, 2'b01);
        check({tag, "_arcache"}, arcache, 4'b0011);
        check({tag, "_arprot"}, arprot, 3'b100);
        check({tag, "_arid"}, arid, 13'd0);
        check({tag, "_arlock"}, arlock, 1'b0);
        for (int h = 0; h < hold; h++) begin
            tick();
            check({tag, "_hold_valid"}, arvalid, 1'b1);
            check({tag, "_hold_addr"}, araddr, exp_addr);
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] base, input int b, input logic zero,
                             input logic [1:0] resp);
        logic [63:0] lo;
        lo     = base + 64'(8 * b);
        rvalid = 1'b1;
        rdata  = zero ? 64'h0 : {mem_word(lo + 64'd4), mem_word(lo)};
        rresp  = resp;
        rlast  = (b == 7);
        check($sformatf("rready_b%0d", b), rready, 1'b1);
        tick();
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
        rdata  = '0;
    endtask

    task automatic send_burst(input logic [63:0] base, input logic [63:0] first_pc,
                              input int zero_beat, input int err_beat, input logic [1:0] resp);
        for (int b = 0; b < 8; b++) begin
            send_beat(base, b, b == zero_beat, (b == err_beat) ? resp : 2'b00);
            if (b == 0) begin
                if (zero_beat == 0 || err_beat == 0) begin
                    check("lat_none", inst_valid, 1'b0);
                end else begin
                    check("lat_valid", inst_valid, 1'b1);
                    check("lat_pc", inst_pc, first_pc);
                end
            end
        end
    endtask

    task automatic check_stream(input string tag, input logic [63:0] first_pc, input int exp_n);
        logic [63:0] pc;
        check({tag, "_count"}, 64'(q_pc.size()), 64'(exp_n));
        for (int i = 0; i < exp_n && i < q_pc.size(); i++) begin
            pc = first_pc + 64'(4 * i);
            check($sformatf("%s_pc%0d", tag, i), q_pc[i], pc);
            check($sformatf("%s_data%0d", tag, i), q_data[i], mem_word(pc));
        end
    endtask

    task automatic count_ar(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int c = 0; c < cycles; c++) begin
            tick();
            if (arvalid) seen++;
        end
        check(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        inst_ready = 1'b1;

        // Aligned entry, full burst, then the sequential next burst.
        do_reset(64'h1000);
        wait_ar("a_ar1", 64'h1000, 2);
        check("a_pre_valid", inst_valid, 1'b0);
        send_burst(64'h1000, 64'h1000, -1, -1, 2'b00);
        wait_ar("a_ar2", 64'h1040, 0);
        check_stream("a", 64'h1000, 16);

        // Mid-beat entry: first lane skipped.
        do_reset(64'h1004);
        wait_ar("b_ar1", 64'h1000, 0);
        send_burst(64'h1000, 64'h1004, -1, -1, 2'b00);
        wait_ar("b_ar2", 64'h1040, 0);
        check_stream("b", 64'h1004, 15);

        // Stalled consumer: one burst fills the buffer, AR waits for 16 free.
        inst_ready = 1'b0;
        do_reset(64'h1000);
        wait_ar("c_ar1", 64'h1000, 0);
        send_burst(64'h1000, 64'h1000, -1, -1, 2'b00);
        count_ar("c_no_ar_full", 10);
        check("c_head_pc", inst_pc, 64'h1000);
        inst_ready = 1'b1;
        repeat (15) tick();
        inst_ready = 1'b0;
        check("c_one_left_valid", inst_valid, 1'b1);
        check("c_one_left_pc", inst_pc, 64'h103C);
        count_ar("c_no_ar_15free", 5);
        inst_ready = 1'b1;
        wait_ar("c_ar2", 64'h1040, 0);
        check_stream("c", 64'h1000, 16);

        // All-zero beat 3: halt, drain, stop, then redirect recovers.
        do_reset(64'h1000);
        wait_ar("d_ar1", 64'h1000, 0);
        send_burst(64'h1000, 64'h1000, 3, -1, 2'b00);
        check("d_halt", halt, 1'b1);
        check("d_bus_err", bus_err, 1'b0);
        repeat (5) tick();
        check_stream("d", 64'h1000, 6);
        count_ar("d_no_ar_stop", 20);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h2000;
        tick();
        redirect_valid = 1'b0;
        check("d_halt_clr", halt, 1'b0);
        wait_ar("d_ar2", 64'h2000, 0);

        // Redirect on beat 2: buffer flushed, rest of burst discarded.
        do_reset(64'h1000);
        wait_ar("e_ar1", 64'h1000, 0);
        send_beat(64'h1000, 0, 1'b0, 2'b00);
        send_beat(64'h1000, 1, 1'b0, 2'b00);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h3008;
        send_beat(64'h1000, 2, 1'b0, 2'b00);
        redirect_valid = 1'b0;
        check("e_flushed", inst_valid, 1'b0);
        q_pc.delete();
        q_data.delete();
        for (int b = 3; b < 8; b++) begin
            send_beat(64'h1000, b, 1'b0, 2'b00);
        end
        check("e_discard_valid", inst_valid, 1'b0);
        check("e_discard_count", 64'(q_pc.size()), 64'd0);
        wait_ar("e_ar2", 64'h3008, 0);
        send_burst(64'h3008, 64'h3008, -1, -1, 2'b00);
        wait_ar("e_ar3", 64'h3048, 0);
        check_stream("e", 64'h3008, 16);

        // SLVERR on beat 0: bus_err, nothing pushed, stop after rlast.
        do_reset(64'h1000);
        wait_ar("f_ar1", 64'h1000, 0);
        send_burst(64'h1000, 64'h1000, -1, 0, 2'b10);
        check("f_bus_err", bus_err, 1'b1);
        check("f_halt", halt, 1'b0);
        check("f_inst_valid", inst_valid, 1'b0);
        check("f_count", 64'(q_pc.size()), 64'd0);
        count_ar("f_no_ar_stop", 20);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h4000;
        tick();
        redirect_valid = 1'b0;
        check("f_bus_err_clr", bus_err, 1'b0);
        wait_ar("f_ar2", 64'h4000, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_fetch_unit.md
AXI_FETCH_UNIT -- requirements
Module: axi_fetch_unit

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- ID_WIDTH, 13, AXI ID width.
- ADDR_WIDTH, 64, address width.
- DATA_WIDTH, 64, read data width; multiple of 32, at least 64.
- BURST_LEN, 8, beats per AR burst (1..16).
- FIFO_DEPTH, 16, instruction buffer entries; power of 2, at least BURST_LEN*DATA_WIDTH/32.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1, sole clock; one clock, all logic on rising edge.
- reset, in, 1, synchronous, active-high.
- entry, in, ADDR_WIDTH, start PC, sampled during reset.
- redirect_valid, in, 1, one-cycle PC redirect request.
- redirect_pc, in, ADDR_WIDTH, redirect target, 4-byte aligned.
- m_axi_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid, out, standard AXI4 AR channel.
- m_axi_arready, in, 1.
- m_axi_rid/rdata/rresp/rlast/rvalid, in, standard AXI4 R channel.
- m_axi_rready, out, 1.
- inst_valid, out, 1, instruction available.
- inst_ready, in, 1, consumer accepts.
- inst_data, out, 32, instruction word.
- inst_pc, out, ADDR_WIDTH, PC of inst_data.
- halt, out, 1, sticky; all-zero beat received.
- bus_err, out, 1, sticky; non-OKAY rresp received.

Function
REQ-003 N = DATA_WIDTH/32 instructions per beat; beat B lane k (bits 32k+31:32k) SHALL carry the PC at burst base + B*DATA_WIDTH/8 + 4k.
REQ-004 FSM states SHALL be IDLE, ADDR, DATA, FLUSH, STOP.
REQ-005 IDLE->ADDR SHALL occur when FIFO free entries >= BURST_LEN*N and halt=0; otherwise the block SHALL remain in IDLE.
REQ-006 In ADDR the block SHALL drive arvalid=1 and hold araddr = fetch_pc with low log2(DATA_WIDTH/8) bits cleared, arlen=BURST_LEN-1, arsize=log2(DATA_WIDTH/8), arburst=INCR (01), arid=0, arlock=0, arcache=0011, arprot=100 (instruction), with all AR fields stable until arready; on handshake the block SHALL go to DATA.
REQ-007 In DATA rready SHALL be 1; each accepted beat SHALL push lanes in ascending PC order, skipping lanes whose PC < fetch_pc (mid-beat entry/redirect).
REQ-008 fetch_pc SHALL become burst base + BURST_LEN*DATA_WIDTH/8 on the rlast beat, and the FSM SHALL then return to IDLE.
REQ-009 A beat with rdata==0 SHALL set halt, push no lanes from that beat, and move the FSM to FLUSH (if not rlast) or STOP.
REQ-010 rresp!=00 SHALL set bus_err, discard the beat and behave as REQ-009 (halt not set).
REQ-011 In FLUSH, rready SHALL be 1 and beats SHALL be discarded until rlast; then the FSM SHALL go to IDLE, or to STOP if halt or bus_err is set.
REQ-012 STOP SHALL issue no AR; it SHALL exit only via reset or redirect (redirect clears halt and bus_err).
REQ-013 redirect_valid SHALL, in the same cycle, flush the FIFO and load fetch_pc=redirect_pc; state SHALL go IDLE from IDLE/ADDR-after-handshake/STOP, FLUSH from DATA; in ADDR before arready the block SHALL keep arvalid/araddr stable and then go to FLUSH.
REQ-014 Redirect and a FIFO push in the same cycle: redirect SHALL win; no stale entry SHALL survive.
REQ-015 The FIFO SHALL present first-word fall-through: inst_valid=~empty, with inst_data/inst_pc = head; a pop SHALL occur on inst_valid&inst_ready; simultaneous push and pop SHALL keep the count consistent.
REQ-016 Pushes SHALL never overflow the FIFO; the admission check in REQ-005 guarantees space for a full burst.
REQ-017 Latency: AR handshake to first inst_valid SHALL be rvalid+1 cycle (registered FIFO write).

Reset
REQ-018 While reset=1: state=IDLE, fetch_pc=entry, FIFO empty, arvalid=0, rready=0, inst_valid=0, halt=0, bus_err=0, other AR outputs 0.
REQ-019 Reset mid-burst SHALL abandon the burst without draining; the bus is assumed reset concurrently.

Configuration
REQ-020 With FETCH_TRACE_EN defined, each FIFO pop SHALL $display "PC 0x<pc>: Instruction 0x<inst>"; without the macro, no display code SHALL be compiled, with identical cycle behaviour.

Verification
REQ-021 entry=0x1000, defaults, memory increasing words, inst_ready=1 -> AR araddr=0x1000 arlen=7 arburst=01; 16 instructions with PCs 0x1000..0x103C in order; second AR at 0x1040.
REQ-022 entry=0x1004 -> araddr=0x1000; first inst_pc=0x1004; 15 instructions pushed from the first burst.
REQ-023 inst_ready=0 throughout -> exactly one burst, FIFO full (16), no further AR until pops free 16 entries.
REQ-024 Beat 3 all-zero -> 6 instructions output, remaining beats drained, halt=1, no further AR; redirect_pc=0x2000 -> halt=0, AR at 0x2000.
REQ-025 redirect_pc=0x3008 asserted on beat 2 of a burst -> FIFO emptied, remaining beats discarded, next AR araddr=0x3008, first inst_pc=0x3008.
REQ-026 rresp=10 on beat 0 -> bus_err=1, no instructions pushed, STOP after rlast.
